pixel_frame_capture: RTL

PIXEL_FRAME_CAPTURE -- requirements
Module: pixel_frame_capture

---
 rtl/pixel_frame_capture.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_capture.sv
// Pixel frame capture buffer: captures one RGB frame into on-chip memory,
// then streams it out with valid/ready handshaking and row/last markers.
module pixel_frame_capture #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SUM_PIXEL = 300,
  parameter int unsigned ROW_LEN   = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             PixelValid,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadReq,
  input  logic             RdReady,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic [WIDTH-1:0] R_rd,
  output logic [WIDTH-1:0] G_rd,
  output logic [WIDTH-1:0] B_rd,
  output logic             RdValid,
  output logic             RdRowEnd,
  output logic             RdLast
);

  localparam int unsigned PTR_W = (SUM_PIXEL > 1) ? $clog2(SUM_PIXEL) : 1;
  localparam int unsigned ROW_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SUM_PIXEL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FULL    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_row_end_q, rd_row_end_d;
  logic               rd_last_q, rd_last_d;
  logic [WIDTH-1:0]   r_rd_q, r_rd_d;
  logic [WIDTH-1:0]   g_rd_q, g_rd_d;
  logic [WIDTH-1:0]   b_rd_q, b_rd_d;

  logic               wr_en_c;
  logic [PTR_W-1:0]   rd_addr_c;

  // Frame storage, one array per colour component; never reset.
  logic [WIDTH-1:0]   mem_r [SUM_PIXEL];
  logic [WIDTH-1:0]   mem_g [SUM_PIXEL];
  logic [WIDTH-1:0]   mem_b [SUM_PIXEL];

  // Next-state and registered-output logic for the capture/readout sequencer.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    row_d        = row_q;
    ovf_d        = ovf_q;
    rd_valid_d   = rd_valid_q;
    rd_row_end_d = rd_row_end_q;
    rd_last_d    = rd_last_q;
    r_rd_d       = r_rd_q;
    g_rd_d       = g_rd_q;
    b_rd_d       = b_rd_q;
    wr_en_c      = 1'b0;
    rd_addr_c    = rd_ptr_q;

    // Once a pixel is presented, the next fetch address is one ahead.
    if (rd_valid_q && !rd_last_q) begin
      rd_addr_c = rd_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (PixelValid) begin
          wr_en_c = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            state_d = S_FULL;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end

      S_FULL: begin
        // Start wins over ReadReq and discards the stored frame.
        if (Start) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
        end else begin
          if (PixelValid) begin
            ovf_d = 1'b1;
          end
          if (ReadReq) begin
            state_d    = S_READOUT;
            rd_ptr_d   = '0;
            row_d      = '0;
            rd_valid_d = 1'b0;
          end
        end
      end

      S_READOUT: begin
        if (!rd_valid_q) begin
          // First cycle after entry: present pixel 0.
          rd_valid_d   = 1'b1;
          rd_row_end_d = (row_q == ROW_LAST);
          rd_last_d    = (rd_ptr_q == LAST_IDX);
          r_rd_d       = mem_r[rd_addr_c];
          g_rd_d       = mem_g[rd_addr_c];
          b_rd_d       = mem_b[rd_addr_c];
        end else if (RdReady) begin
          if (rd_last_q) begin
            state_d      = S_IDLE;
            rd_valid_d   = 1'b0;
            rd_row_end_d = 1'b0;
            rd_last_d    = 1'b0;
          end else begin
            rd_ptr_d     = rd_addr_c;
            row_d        = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            rd_valid_d   = 1'b1;
            rd_row_end_d = (row_d == ROW_LAST);
            rd_last_d    = (rd_addr_c == LAST_IDX);
            r_rd_d       = mem_r[rd_addr_c];
            g_rd_d       = mem_g[rd_addr_c];
            b_rd_d       = mem_b[rd_addr_c];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CAPTURE) || (state_d == S_READOUT);
    done_d = (state_d == S_FULL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_row_end_q <= 1'b0;
      rd_last_q    <= 1'b0;
      r_rd_q       <= '0;
      g_rd_q       <= '0;
      b_rd_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_valid_d;
      rd_row_end_q <= rd_row_end_d;
      rd_last_q    <= rd_last_d;
      r_rd_q       <= r_rd_d;
      g_rd_q       <= g_rd_d;
      b_rd_q       <= b_rd_d;
    end
  end

  // Pixel write port; gated by reset so an aborting cycle leaves memory alone.
  always_ff @(posedge Clock) begin
    if (Reset && wr_en_c) begin
      mem_r[wr_ptr_q] <= R;
      mem_g[wr_ptr_q] <= G;
      mem_b[wr_ptr_q] <= B;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Overflow = ovf_q;
  assign RdValid  = rd_valid_q;
  assign RdRowEnd = rd_row_end_q;
  assign RdLast   = rd_last_q;
  assign R_rd     = r_rd_q;
  assign G_rd     = g_rd_q;
  assign B_rd     = b_rd_q;

endmodule
